alu_issue: RTL and testbench

Issue front end for the execute-stage ALU. It accepts tagged operations from decode over a valid/ready handshake and buffers them in a request FIFO. It drives the ALU's `valid/command/in_a/in_b` and tracks the ALU's one-cycle registered latency. It returns each result with its tag through a 2-entry response buffer with backpressure, and can chain an operation's `in_a` onto the previous result.

---
 rtl/alu_issue.sv | 171 +++++++++++++++++
 tb/tb_alu_issue.sv | 304 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_issue.sv
// Issue front end for the execute-stage ALU: request FIFO, one-deep in-flight
// tracking of the registered ALU, result forwarding and a 2-entry response buffer.
module alu_issue #(
    parameter int DEPTH = 4,
    parameter int TAG_W = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic [2:0]       req_cmd,
    input  logic [31:0]      req_a,
    input  logic [31:0]      req_b,
    input  logic             req_fwd_a,
    input  logic [TAG_W-1:0] req_tag,
    output logic             alu_valid,
    output logic [2:0]       alu_command,
    output logic [31:0]      alu_in_a,
    output logic [31:0]      alu_in_b,
    input  logic [31:0]      alu_result,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic [31:0]      rsp_data,
    output logic [TAG_W-1:0] rsp_tag,
    output logic             idle
);
    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = PTR_W + 1;

    typedef struct packed {
        logic [2:0]       cmd;
        logic [31:0]      a;
        logic [31:0]      b;
        logic             fwd;
        logic [TAG_W-1:0] tag;
    } req_t;

    req_t             req_in;
    req_t             head;
    req_t             mem_view [DEPTH];
    logic [PTR_W-1:0] wr_ptr_reg;
    logic [PTR_W-1:0] rd_ptr_reg;
    logic [CNT_W-1:0] count_reg;
    logic [CNT_W-1:0] count_next;
    logic             req_push;
    logic             issue;
    logic             fifo_empty;

    logic             inflight_reg;
    logic [TAG_W-1:0] inflight_tag_reg;
    logic             issued_any_reg;

    logic             out_wr_reg;
    logic             out_rd_reg;
    logic [1:0]       out_count_reg;
    logic [1:0]       out_count_next;
    logic             rsp_push;
    logic             rsp_pop;
    logic [2:0]       credit_used;

    assign req_in     = '{cmd: req_cmd, a: req_a, b: req_b, fwd: req_fwd_a, tag: req_tag};
    assign fifo_empty = (count_reg == '0);
    assign req_ready  = (count_reg < CNT_W'(DEPTH));
    assign req_push   = req_valid && req_ready;

    assign rsp_valid   = (out_count_reg != 2'd0);
    assign rsp_pop     = rsp_valid && rsp_ready;
    assign rsp_push    = inflight_reg;
    // Results already buffered or in the ALU pipe, minus the one leaving now.
    assign credit_used = {1'b0, out_count_reg} + {2'b00, inflight_reg} - {2'b00, rsp_pop};
    assign issue       = !fifo_empty && (credit_used < 3'd2);

    assign head        = mem_view[rd_ptr_reg];
    assign alu_valid   = issue;
    assign alu_command = head.cmd;
    assign alu_in_b    = head.b;
    // Before the first issue the ALU output is meaningless, so forward zero.
    assign alu_in_a    = head.fwd ? (issued_any_reg ? alu_result : 32'd0) : head.a;

    assign idle = fifo_empty && !inflight_reg && (out_count_reg == 2'd0);

    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_entry
        req_t entry_reg;
        always_ff @(posedge clk or negedge reset) begin
            if (!reset) begin
                entry_reg <= '0;
            end else if (req_push && (wr_ptr_reg == PTR_W'(gi))) begin
                entry_reg <= req_in;
            end
        end
        assign mem_view[gi] = entry_reg;
    end

    always_comb begin
        count_next = count_reg;
        case ({req_push, issue})
            2'b10:   count_next = count_reg + CNT_W'(1);
            2'b01:   count_next = count_reg - CNT_W'(1);
            default: count_next = count_reg;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else begin
            if (req_push) wr_ptr_reg <= wr_ptr_reg + PTR_W'(1);
            if (issue)    rd_ptr_reg <= rd_ptr_reg + PTR_W'(1);
            count_reg <= count_next;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            inflight_reg     <= 1'b0;
            inflight_tag_reg <= '0;
            issued_any_reg   <= 1'b0;
        end else begin
            inflight_reg <= issue;
            if (issue) begin
                inflight_tag_reg <= head.tag;
                issued_any_reg   <= 1'b1;
            end
        end
    end

    for (genvar gi = 0; gi < 2; gi++) begin : g_out
        logic [31:0]      data_reg;
        logic [TAG_W-1:0] tag_reg;
        always_ff @(posedge clk or negedge reset) begin
            if (!reset) begin
                data_reg <= '0;
                tag_reg  <= '0;
            end else if (rsp_push && (out_wr_reg == 1'(gi))) begin
                data_reg <= alu_result;
                tag_reg  <= inflight_tag_reg;
            end
        end
    end

    assign rsp_data = out_rd_reg ? g_out[1].data_reg : g_out[0].data_reg;
    assign rsp_tag  = out_rd_reg ? g_out[1].tag_reg  : g_out[0].tag_reg;

    always_comb begin
        out_count_next = out_count_reg;
        case ({rsp_push, rsp_pop})
            2'b10:   out_count_next = out_count_reg + 2'd1;
            2'b01:   out_count_next = out_count_reg - 2'd1;
            default: out_count_next = out_count_reg;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            out_wr_reg    <= 1'b0;
            out_rd_reg    <= 1'b0;
            out_count_reg <= 2'd0;
        end else begin
            if (rsp_push) out_wr_reg <= ~out_wr_reg;
            if (rsp_pop)  out_rd_reg <= ~out_rd_reg;
            out_count_reg <= out_count_next;
        end
    end

    // A write into a full buffer with no simultaneous drain would drop a result.
    a_rsp_no_overflow: assert property (@(posedge clk) disable iff (!reset)
        !(rsp_push && (out_count_reg == 2'd2) && !rsp_pop));

endmodule

// File: tb/tb_alu_issue.sv
// Self-checking bench for alu_issue with a behavioural registered ALU and an
// in-order scoreboard of expected {data, tag} responses.
module tb_alu_issue;
    localparam int DEPTH = 4;
    localparam int TAG_W = 4;
    localparam logic [2:0] OP_ADD = 3'd0;
    localparam logic [2:0] OP_SUB = 3'd1;
    localparam logic [2:0] OP_AND = 3'd2;
    localparam logic [2:0] OP_OR  = 3'd3;

    logic             clk;
    logic             reset;
    logic             req_valid;
    logic             req_ready;
    logic [2:0]       req_cmd;
    logic [31:0]      req_a;
    logic [31:0]      req_b;
    logic             req_fwd_a;
    logic [TAG_W-1:0] req_tag;
    logic             alu_valid;
    logic [2:0]       alu_command;
    logic [31:0]      alu_in_a;
    logic [31:0]      alu_in_b;
    logic [31:0]      alu_result = 32'd0;
    logic             rsp_valid;
    logic             rsp_ready;
    logic [31:0]      rsp_data;
    logic [TAG_W-1:0] rsp_tag;
    logic             idle;

    int checks = 0;
    int failures = 0;
    int cyc = 0;
    int issue_cnt = 0;
    int accept_cnt = 0;
    int accept_before;
    bit rand_rdy = 1'b0;
    logic [31:0] prev_res = 32'd0;

    typedef struct packed {
        logic [31:0]      data;
        logic [TAG_W-1:0] tag;
    } rsp_t;
    rsp_t exp_q [$];
    rsp_t mon_e;
    int   rsp_cyc [$];

    typedef struct packed {
        logic [2:0]       cmd;
        logic [31:0]      a;
        logic [31:0]      b;
        logic             fwd;
        logic [TAG_W-1:0] tag;
        logic [31:0]      exp;
    } vec_t;
    vec_t vecs [4];

    logic [2:0]       g_cmd;
    logic [31:0]      g_a;
    logic [31:0]      g_b;
    logic             g_fwd;
    logic [TAG_W-1:0] g_tag;
    logic [31:0]      g_exp;

    alu_issue #(.DEPTH(DEPTH), .TAG_W(TAG_W)) dut (
        .clk(clk), .reset(reset),
        .req_valid(req_valid), .req_ready(req_ready), .req_cmd(req_cmd),
        .req_a(req_a), .req_b(req_b), .req_fwd_a(req_fwd_a), .req_tag(req_tag),
        .alu_valid(alu_valid), .alu_command(alu_command),
        .alu_in_a(alu_in_a), .alu_in_b(alu_in_b), .alu_result(alu_result),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_data(rsp_data), .rsp_tag(rsp_tag), .idle(idle)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #500000;
        $display("FAIL watchdog time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic logic [31:0] calc(input logic [2:0] cmd, input logic [31:0] a, input logic [31:0] b);
        case (cmd)
            OP_ADD:  return a + b;
            OP_SUB:  return a - b;
            OP_AND:  return a & b;
            OP_OR:   return a | b;
            default: return 32'd0;
        endcase
    endfunction

    // Behavioural ALU: registered result, held while valid is low, not reset.
    always @(posedge clk) begin
        if (alu_valid) alu_result <= calc(alu_command, alu_in_a, alu_in_b);
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    always @(posedge clk) begin
        cyc++;
        if (reset) begin
            if (alu_valid) issue_cnt++;
            if (req_valid && req_ready) accept_cnt++;
            if (rsp_valid && rsp_ready) begin
                rsp_cyc.push_back(cyc);
                if (exp_q.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL rsp_unexpected actual data=%0h tag=%0d required none", rsp_data, rsp_tag);
                end else begin
                    mon_e = exp_q.pop_front();
                    $display("rsp tag=%0d data=%0h expected tag=%0d data=%0h", rsp_tag, rsp_data, mon_e.tag, mon_e.data);
                    chk("rsp_data", rsp_data, mon_e.data);
                    chk("rsp_tag", 32'(rsp_tag), 32'(mon_e.tag));
                end
            end
        end
    end

    initial begin
        forever begin
            @(negedge clk);
            if (rand_rdy) rsp_ready = ($urandom_range(0, 2) != 0);
        end
    end

    // Called at a negedge; holds the request until accepted, returns at the following negedge.
    task automatic send(input logic [2:0] cmd, input logic [31:0] a, input logic [31:0] b,
                        input logic fwd, input logic [TAG_W-1:0] tag, input logic [31:0] exp);
        int n;
        req_cmd = cmd; req_a = a; req_b = b; req_fwd_a = fwd; req_tag = tag;
        req_valid = 1'b1;
        n = 0;
        while (!req_ready && n < 300) begin
            @(negedge clk);
            n++;
        end
        if (!req_ready) begin
            checks++;
            failures++;
            $display("FAIL send_timeout actual req_ready=0 required 1 tag=%0d", tag);
        end else begin
            exp_q.push_back({exp, tag});
        end
        prev_res = exp;
        @(negedge clk);
    endtask

    task automatic gen_op(input int i);
        g_cmd = 3'(i % 4);
        g_a   = 32'(i * 3 + 1);
        g_b   = 32'(i + 2);
        g_fwd = (i % 2 == 1);
        g_tag = TAG_W'(i + 4);
        g_exp = calc(g_cmd, g_fwd ? prev_res : g_a, g_b);
    endtask

    task automatic drain(input string name);
        int n;
        n = 0;
        while ((exp_q.size() != 0 || !idle) && n < 300) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (exp_q.size() != 0 || !idle) begin
            failures++;
            $display("FAIL %s actual pending=%0d idle=%0b required pending=0 idle=1", name, exp_q.size(), idle);
        end
    endtask

    task automatic check_reset_outputs(input string tag_s);
        chk({tag_s, "_req_ready"}, 32'(req_ready), 32'd1);
        chk({tag_s, "_alu_valid"}, 32'(alu_valid), 32'd0);
        chk({tag_s, "_rsp_valid"}, 32'(rsp_valid), 32'd0);
        chk({tag_s, "_rsp_data"},  rsp_data, 32'd0);
        chk({tag_s, "_rsp_tag"},   32'(rsp_tag), 32'd0);
        chk({tag_s, "_idle"},      32'(idle), 32'd1);
    endtask

    initial begin
        vecs[0] = '{OP_ADD, 32'd5,         32'd7,  1'b0, 4'd3, 32'd12};
        vecs[1] = '{OP_ADD, 32'd10,        32'd20, 1'b0, 4'd1, 32'd30};
        vecs[2] = '{OP_SUB, 32'hDEAD_BEEF, 32'd5,  1'b1, 4'd2, 32'd25};
        vecs[3] = '{OP_AND, 32'h1234_5678, 32'hF,  1'b1, 4'd3, 32'd9};

        reset = 1'b1; req_valid = 1'b0; rsp_ready = 1'b1;
        req_cmd = '0; req_a = '0; req_b = '0; req_fwd_a = 1'b0; req_tag = '0;
        #3 reset = 1'b0;
        #1 check_reset_outputs("init");
        repeat (3) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);

        // Single op: issue pulse, 3-cycle latency, back to idle.
        issue_cnt = 0;
        send(vecs[0].cmd, vecs[0].a, vecs[0].b, vecs[0].fwd, vecs[0].tag, vecs[0].exp);
        req_valid = 1'b0;
        chk("t1_issue_cycle", 32'(alu_valid), 32'd1);
        chk("t1_no_early_rsp", 32'(rsp_valid), 32'd0);
        @(negedge clk);
        chk("t1_issue_pulse_end", 32'(alu_valid), 32'd0);
        chk("t1_rsp_not_yet", 32'(rsp_valid), 32'd0);
        @(negedge clk);
        chk("t1_rsp_latency", 32'(rsp_valid), 32'd1);
        @(negedge clk);
        chk("t1_idle", 32'(idle), 32'd1);
        chk("t1_issue_count", 32'(issue_cnt), 32'd1);

        // Forward chain, back to back.
        rsp_cyc.delete();
        for (int i = 1; i < 4; i++)
            send(vecs[i].cmd, vecs[i].a, vecs[i].b, vecs[i].fwd, vecs[i].tag, vecs[i].exp);
        req_valid = 1'b0;
        drain("t2_drain");
        chk("t2_rsp_count", 32'(rsp_cyc.size()), 32'd3);
        if (rsp_cyc.size() == 3) chk("t2_consecutive", 32'(rsp_cyc[2] - rsp_cyc[0]), 32'd2);

        // Backpressure: six ops, only two may issue, FIFO fills.
        rsp_ready = 1'b0;
        issue_cnt = 0;
        for (int i = 0; i < 6; i++) begin
            gen_op(i);
            send(g_cmd, g_a, g_b, g_fwd, g_tag, g_exp);
        end
        gen_op(6);
        req_cmd = g_cmd; req_a = g_a; req_b = g_b; req_fwd_a = g_fwd; req_tag = g_tag;
        req_valid = 1'b1;
        accept_before = accept_cnt;
        repeat (3) @(negedge clk);
        chk("t3_req_ready_low", 32'(req_ready), 32'd0);
        chk("t3_issue_count", 32'(issue_cnt), 32'd2);
        chk("t4_no_push_full", 32'(accept_cnt), 32'(accept_before));
        chk("t3_rsp_valid", 32'(rsp_valid), 32'd1);
        rsp_ready = 1'b1;
        #1 chk("t4_release_same_cycle", 32'(alu_valid), 32'd1);
        @(negedge clk);
        chk("t4_ready_after_pop", 32'(req_ready), 32'd1);
        send(g_cmd, g_a, g_b, g_fwd, g_tag, g_exp);
        chk("t4_push_resumed", 32'(accept_cnt), 32'(accept_before + 1));
        for (int i = 7; i < 14; i++) begin
            gen_op(i);
            send(g_cmd, g_a, g_b, g_fwd, g_tag, g_exp);
        end
        req_valid = 1'b0;
        drain("t3_drain");

        // Reset with work queued, buffered and in flight.
        rsp_ready = 1'b0;
        send(OP_ADD, 32'd100, 32'd1, 1'b0, 4'd1, 32'd101);
        send(OP_SUB, 32'd0,   32'd1, 1'b1, 4'd2, 32'd100);
        send(OP_OR,  32'd8,   32'd1, 1'b0, 4'd3, 32'd9);
        send(OP_ADD, 32'd7,   32'd7, 1'b0, 4'd4, 32'd14);
        req_valid = 1'b0;
        #2 reset = 1'b0;
        #1 check_reset_outputs("t5_async");
        exp_q.delete();
        prev_res = 32'd0;
        repeat (2) @(negedge clk);
        reset = 1'b1;
        rsp_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("t5_no_stale_rsp", 32'(rsp_valid), 32'd0);
        end
        send(OP_ADD, 32'd99, 32'd4, 1'b1, 4'd5, 32'd4);
        req_valid = 1'b0;
        drain("t5_drain");

        // Randomized traffic against the scoreboard.
        rand_rdy = 1'b1;
        for (int i = 0; i < 120; i++) begin
            if ($urandom_range(0, 3) == 0) begin
                req_valid = 1'b0;
                @(negedge clk);
            end
            g_cmd = 3'($urandom_range(0, 3));
            g_a   = $urandom;
            g_b   = $urandom;
            g_fwd = 1'($urandom_range(0, 1));
            g_tag = TAG_W'(i);
            g_exp = calc(g_cmd, g_fwd ? prev_res : g_a, g_b);
            send(g_cmd, g_a, g_b, g_fwd, g_tag, g_exp);
        end
        req_valid = 1'b0;
        rand_rdy = 1'b0;
        rsp_ready = 1'b1;
        drain("t6_drain");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
